// File: rtl/deck_picker.sv
`default_nettype none
// ============================================================================
// Module   : deck_picker
// Brief    : Random card-draw selector. On req, snapshots available_card and
//            scans it one slot per cycle from an LFSR-derived start point,
//            returning the first drawable slot or a fail pulse if none.
//            Optional macro DECK_PICKER_DETERMINISTIC_EN forces start index 0.
// Revision : 1.0 - initial release
// ============================================================================
module deck_picker #(
  parameter int          N_SLOTS   = 106,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [N_SLOTS-1:0] available_card,
  output logic               busy,
  output logic               card_valid,
  output logic               card_fail,
  output logic [6:0]         card_idx,
  output logic [5:0]         card
);

  localparam logic [6:0]  LAST_SLOT   = 7'(N_SLOTS - 1);
  localparam logic [6:0]  SLOT_COUNT  = 7'(N_SLOTS);
  localparam logic [6:0]  SECOND_BASE = 7'd54;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [15:0]        lfsr;
  logic [6:0]         start_idx;
  logic [N_SLOTS-1:0] snap;
  logic [6:0]         ptr;
  logic [6:0]         miss_cnt;
  logic               result_hit;

  // Free-running Galois LFSR; the moment of the request supplies the entropy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr[0]) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ LFSR_TAPS;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]};
    end
  end

  // Map the low LFSR bits onto a legal slot number (single conditional subtract).
  always_comb begin
`ifdef DECK_PICKER_DETERMINISTIC_EN
    start_idx = 7'd0;
`else
    start_idx = lfsr[6:0];
    if (lfsr[6:0] >= SLOT_COUNT) begin
      start_idx = lfsr[6:0] - SLOT_COUNT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Scan datapath: snapshot on accept, walk the pointer, capture the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap       <= '0;
      ptr        <= '0;
      miss_cnt   <= '0;
      card_idx   <= '0;
      result_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            snap     <= available_card;
            ptr      <= start_idx;
            miss_cnt <= '0;
          end
        end
        SCAN: begin
          if (snap[ptr]) begin
            card_idx   <= ptr;
            result_hit <= 1'b1;
          end else if (miss_cnt == LAST_SLOT) begin
            result_hit <= 1'b0;
          end else begin
            ptr      <= (ptr == LAST_SLOT) ? 7'd0 : ptr + 7'd1;
            miss_cnt <= miss_cnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and status outputs; the result pulse is exactly the DONE cycle.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    card_valid = 1'b0;
    card_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (snap[ptr] || (miss_cnt == LAST_SLOT)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        card_valid = result_hit;
        card_fail  = !result_hit;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Fold the second copy of the deck back onto card codes 0-51.
  always_comb begin
    card = card_idx[5:0];
    if (card_idx >= SECOND_BASE) begin
      card = 6'(card_idx - SECOND_BASE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deck_picker.sv
`default_nettype none
// ============================================================================
// Module   : tb_deck_picker
// Brief    : Self-checking bench for deck_picker. Each table vector resets the
//            DUT and requests in the first cycle after release, so the start
//            index is fixed (97 from seed 16'hACE1, or 0 in deterministic mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_deck_picker;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [105:0] available_card;
  logic         busy;
  logic         card_valid;
  logic         card_fail;
  logic [6:0]   card_idx;
  logic [5:0]   card;

  int tests = 0;
  int fails = 0;

  deck_picker dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .available_card (available_card),
    .busy           (busy),
    .card_valid     (card_valid),
    .card_fail      (card_fail),
    .card_idx       (card_idx),
    .card           (card)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [105:0] av;
    int           clr_cyc;  // cycle in which available_card is zeroed (-1 = never)
    int           lat;      // expected pulse cycle (req sampled in cycle 0)
    int           kind;     // 1 = card_valid, 2 = card_fail
    int           idx;
    int           crd;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [105:0] one_hot(input int b);
    logic [105:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Hold reset 3 cycles, then release; the caller's cycle is the first after release.
  task automatic do_reset();
    rst = 1'b0;
    req = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  // Issue one request in the current cycle and observe 112 cycles.
  task automatic run_req(input logic [105:0] av, input int clr_cyc, input bit pester,
                         output int pulse_cyc, output int kind, output int npulse,
                         output int busy_err, output int both_err);
    pulse_cyc      = -1;
    kind           = 0;
    npulse         = 0;
    busy_err       = 0;
    both_err       = 0;
    available_card = av;
    req            = 1'b1;
    for (int cyc = 1; cyc <= 112; cyc++) begin
      step();
      req = pester && (cyc <= 5);
      if (cyc == clr_cyc) available_card = '0;
      if (card_valid && card_fail) both_err++;
      if (card_valid || card_fail) begin
        npulse++;
        if (pulse_cyc < 0) begin
          pulse_cyc = cyc;
          kind      = card_valid ? 1 : 2;
        end
      end
      if (busy != ((pulse_cyc < 0) || (pulse_cyc == cyc))) busy_err++;
    end
  endtask

  initial begin
    int pc, kd, np, be, bo;
    int p_cyc[3];
    int p_idx[3];
    int n;
    logic [105:0] full;
    full           = '1;
    rst            = 1'b0;
    req            = 1'b0;
    available_card = '0;

`ifdef DECK_PICKER_DETERMINISTIC_EN
    vecs[0]  = '{full,                          -1,   2, 1,   0,  0};
    vecs[1]  = '{one_hot(3),                    -1,   5, 1,   3,  3};
    vecs[2]  = '{one_hot(60),                    5,  62, 1,  60,  6};
    vecs[3]  = '{one_hot(97),                   -1,  99, 1,  97, 43};
    vecs[4]  = '{one_hot(96),                   -1,  98, 1,  96, 42};
    vecs[5]  = '{one_hot(105),                  -1, 107, 1, 105, 51};
    vecs[6]  = '{one_hot(0),                    -1,   2, 1,   0,  0};
    vecs[7]  = '{one_hot(53),                   -1,  55, 1,  53, 53};
    vecs[8]  = '{one_hot(54),                   -1,  56, 1,  54,  0};
    vecs[9]  = '{'0,                            -1, 107, 2,   0,  0};
    vecs[10] = '{one_hot(10) | one_hot(100),    -1,  12, 1,  10, 10};
`else
    vecs[0]  = '{full,                          -1,   2, 1,  97, 43};
    vecs[1]  = '{one_hot(3),                    -1,  14, 1,   3,  3};
    vecs[2]  = '{one_hot(60),                    5,  71, 1,  60,  6};
    vecs[3]  = '{one_hot(97),                   -1,   2, 1,  97, 43};
    vecs[4]  = '{one_hot(96),                   -1, 107, 1,  96, 42};
    vecs[5]  = '{one_hot(105),                  -1,  10, 1, 105, 51};
    vecs[6]  = '{one_hot(0),                    -1,  11, 1,   0,  0};
    vecs[7]  = '{one_hot(53),                   -1,  64, 1,  53, 53};
    vecs[8]  = '{one_hot(54),                   -1,  65, 1,  54,  0};
    vecs[9]  = '{'0,                            -1, 107, 2,   0,  0};
    vecs[10] = '{one_hot(10) | one_hot(100),    -1,   5, 1, 100, 46};
`endif

    // Reset values and quiet idle with req low.
    do_reset();
    chk("rst_busy",  busy,       0);
    chk("rst_valid", card_valid, 0);
    chk("rst_fail",  card_fail,  0);
    chk("rst_idx",   card_idx,   0);
    chk("rst_card",  card,       0);
    n = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (busy || card_valid || card_fail) n++;
    end
    chk("idle_no_activity", n, 0);

    // Table of directed vectors.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      run_req(vecs[i].av, vecs[i].clr_cyc, 1'b0, pc, kd, np, be, bo);
      chk($sformatf("v%0d_lat",    i), pc,       vecs[i].lat);
      chk($sformatf("v%0d_kind",   i), kd,       vecs[i].kind);
      chk($sformatf("v%0d_idx",    i), card_idx, vecs[i].idx);
      chk($sformatf("v%0d_card",   i), card,     vecs[i].crd);
      chk($sformatf("v%0d_pulses", i), np,       1);
      chk($sformatf("v%0d_busy",   i), be,       0);
      chk($sformatf("v%0d_both",   i), bo,       0);
    end

    // Fail leaves the previous result in card_idx/card.
    do_reset();
    run_req(full, -1, 1'b0, pc, kd, np, be, bo);
    run_req('0, -1, 1'b0, pc, kd, np, be, bo);
    chk("hold_kind", kd, 2);
    chk("hold_lat",  pc, 107);
`ifdef DECK_PICKER_DETERMINISTIC_EN
    chk("hold_idx",  card_idx, 0);
    chk("hold_card", card,     0);
`else
    chk("hold_idx",  card_idx, 97);
    chk("hold_card", card,     43);
`endif

    // Requests during SCAN are ignored.
    do_reset();
    run_req(one_hot(3), -1, 1'b1, pc, kd, np, be, bo);
    chk("pester_pulses", np, 1);
    chk("pester_busy",   be, 0);
`ifdef DECK_PICKER_DETERMINISTIC_EN
    chk("pester_lat",    pc, 5);
`else
    chk("pester_lat",    pc, 14);
`endif

    // Reset in cycle 10 of a scan aborts it with no pulse; a fresh req then works.
    do_reset();
    available_card = one_hot(60);
    req            = 1'b1;
    n              = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      req = 1'b0;
      if (card_valid || card_fail) n++;
    end
    rst = 1'b0;
    step();
    chk("abort_pulses", n, 0);
    chk("abort_busy",   busy, 0);
    chk("abort_valid",  card_valid, 0);
    chk("abort_fail",   card_fail, 0);
    chk("abort_idx",    card_idx, 0);
    rst = 1'b1;
    run_req(one_hot(60), -1, 1'b0, pc, kd, np, be, bo);
    chk("fresh_kind",   kd, 1);
    chk("fresh_idx",    card_idx, 60);
    chk("fresh_card",   card, 6);
    chk("fresh_pulses", np, 1);
`ifdef DECK_PICKER_DETERMINISTIC_EN
    chk("fresh_lat",    pc, 62);
`else
    chk("fresh_lat",    pc, 71);
`endif

    // req held high: re-accepted every time IDLE is reached (LFSR-driven starts).
    do_reset();
    available_card = full;
    req            = 1'b1;
    n              = 0;
    for (int k = 0; k < 3; k++) begin
      p_cyc[k] = -1;
      p_idx[k] = -1;
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      if (card_valid) begin
        if (n < 3) begin
          p_cyc[n] = cyc;
          p_idx[n] = card_idx;
        end
        n++;
      end
    end
    req = 1'b0;
    repeat (3) step();
    chk("held_pulses", n, 3);
    chk("held_cyc0", p_cyc[0], 2);
    chk("held_cyc1", p_cyc[1], 5);
    chk("held_cyc2", p_cyc[2], 8);
`ifdef DECK_PICKER_DETERMINISTIC_EN
    chk("held_idx0", p_idx[0], 0);
    chk("held_idx1", p_idx[1], 0);
    chk("held_idx2", p_idx[2], 0);
`else
    chk("held_idx0", p_idx[0], 97);
    chk("held_idx1", p_idx[1], 28);
    chk("held_idx2", p_idx[2], 19);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deck_picker.md
# deck_picker

Random card-draw selector downstream of the memory handler. On a request from GameControl it scans the 106-bit `available_card` vector from a pseudo-random start point and returns one drawable card. GameControl then issues `DECK_DRAW` with that card, and the memory handler marks it unavailable. This replaces software-style "pick any set bit" with a deterministic-latency, single-cycle-per-slot hardware scan.

## Interface
- `N_SLOTS`, 106, number of deck slots (bits 0–53 first copies, 54–105 second copies of cards 0–51)
- `LFSR_SEED`, 16'hACE1, LFSR reset value (must be non-zero)

- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-low (0 = reset)
- `req`  in  1  draw request, sampled only in IDLE
- `available_card`  in  106  1 = slot drawable (from memory handler)
- `busy`  out  1  high from the cycle after an accepted `req` until the result pulse
- `card_valid`  out  1  one-cycle pulse: `card`/`card_idx` valid
- `card_fail`  out  1  one-cycle pulse: no slot was available
- `card_idx`  out  7  selected slot, 0–105
- `card`  out  6  card code: `card_idx` if < 54, else `card_idx` − 54

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle regardless of state, reset to `LFSR_SEED`. Request timing supplies the entropy.
- Start index: `s = lfsr[6:0]`; if `s ≥ 106`, then `s − 106`. Result is always in 0–105. It is computed from the LFSR value in the cycle `req` is sampled.
- FSM states: IDLE, SCAN, DONE.
  - **IDLE:** when `req` = 1, latch `snap ← available_card`, set `ptr ← start`, clear `miss_cnt`, and go to SCAN.
  - **SCAN:** examine `snap[ptr]`.
    - If 1: register `card_idx ← ptr` and go to DONE with `card_valid`.
    - If 0 and `miss_cnt` = 105: go to DONE with `card_fail`.
    - Otherwise: `ptr ← (ptr == 105) ? 0 : ptr + 1` and `miss_cnt++`.
  - **DONE:** the result pulse is high for exactly this cycle. Unconditionally return to IDLE.
- The snapshot is taken at acceptance. Changes to `available_card` during SCAN are ignored.
- `card` is derived from the registered `card_idx` with a subtract-54 compare.
- `card_idx`/`card` hold their last value after the pulse. `card_fail` leaves them unchanged.

## Timing
- Reset values: `busy` = 0, `card_valid` = 0, `card_fail` = 0, `card_idx` = 0, `card` = 0, state = IDLE, LFSR = `LFSR_SEED`.
- Latency, with `req` high in cycle 0:
  - SCAN occupies cycles 1 through 1+k, where k = number of misses before the hit.
  - `card_valid` is high in cycle 2+k. The minimum is 2 cycles; the maximum is 107 (k = 105).
  - For an all-zero snapshot, `card_fail` is high in cycle 107.
- `busy` is high in cycles 1 through the pulse cycle inclusive. The next `req` is accepted in the cycle after the pulse (IDLE).
- Boundary behaviour:
  - `req` while SCAN or DONE: ignored, not queued.
  - `req` held high: re-accepted every time IDLE is reached.
  - Wrap-around from slot 105 to slot 0 costs no extra cycle.
  - `rst` = 0 mid-scan: next cycle returns to IDLE with all outputs at reset values, and no pulse is emitted.
  - `card_valid` and `card_fail` are never both high.

## Configuration
- `DECK_PICKER_DETERMINISTIC_EN`
  - **Defined:** start index forced to 0, so the lowest available slot is always returned. The LFSR is still instantiated and running, but unused. This mode is for debug and reproducible benches.
  - **Undefined:** start index taken from the LFSR as above.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles, then release → all outputs 0, `busy` = 0. With `req` = 0 no pulse ever occurs.
- **Deterministic, full deck** (`DECK_PICKER_DETERMINISTIC_EN`, `available_card` all 1s): `req` in cycle 0 → `card_valid` in cycle 2, `card_idx` = 0, `card` = 0, `busy` high in cycles 1–2.
- **Deterministic, single slot** (only bit 60 set): `req` → `card_valid` in cycle 62, `card_idx` = 60, `card` = 6. Clearing bit 60 in cycle 5 does not change the result.
- **Empty deck** (all 0s): `req` → `card_fail` in cycle 107, `card_valid` never asserted, `card_idx` unchanged.
- **Random mode, first cycle:** `req` in the first cycle after reset release (LFSR = 16'hACE1) with a full deck → start index 97, `card_valid` in cycle 2, `card_idx` = 97, `card` = 43. With only bit 3 set → wrap-around, `card_idx` = 3 in cycle 2+12 = 14.
- **Interference:**
  - Pulse `req` again in cycles 1–5 of a scan → ignored, exactly one result pulse.
  - Drive `rst` = 0 in cycle 10 of a 62-cycle scan → IDLE next cycle, no pulse.
  - A fresh `req` after release gives a normal result.
